// File: rtl/wb_result_buffer_pkg.sv
// Shared types for the per-unit writeback result buffer.
// Id width here must match the core's instruction id width.
package wb_result_buffer_pkg;

    localparam int ID_W = 8;

    typedef logic [ID_W-1:0] id_t;

    typedef struct packed {
        id_t         id;
        logic [31:0] data;
    } wb_buffer_entry_t;

    // A single-entry buffer still needs a legal 1-bit pointer; it is held at 0.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/wb_result_buffer.sv
// Result FIFO from an execution unit to the writeback arbiter; push-to-head latency 1 cycle, no bypass.
// Backpressure: result_ready drops when full and depends on registered occupancy only, never on wb_ack.
module wb_result_buffer
    import wb_result_buffer_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       result_valid,
    input  id_t                        result_id,
    input  logic [31:0]                result_data,
    output logic                       result_ready,
    output logic                       wb_done,
    output id_t                        wb_id,
    output logic [31:0]                wb_rd,
    input  logic                       wb_ack,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] FULL    = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = (DEPTH > 1) ? PTR_W'(1) : '0;

    wb_buffer_entry_t   mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               push;
    logic               pop;

    // A full buffer refuses a push even when the head retires in the same cycle.
    assign result_ready = (count != FULL);
    assign wb_done      = (count != '0);
    assign push         = result_valid && result_ready;
    assign pop          = wb_ack && wb_done;

    assign wb_id = mem[rd_ptr].id;
    assign wb_rd = mem[rd_ptr].data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= '{id: result_id, data: result_data};
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: doc/wb_result_buffer.md
# wb_result_buffer

Small per-unit result FIFO between an execution unit's result output and the writeback arbiter. Captures the unit's result, an instruction id plus 32-bit data, on a valid/ready handshake. Presents the oldest held result to the writeback arbiter as a done/id/rd triple and retires it when the arbiter acks. This decouples unit issue from writeback arbitration, so a unit that loses arbitration does not stall its own pipeline until the buffer fills.

## Interface
Parameters:
- DEPTH, default 2: number of result entries; power of two, 1..8.

Ports:
- clk  in  1  core clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous, active-low; buffer cleared while low.
- result_valid  in  1  unit presents a result this cycle.
- result_id  in  id_t  instruction id of the presented result.
- result_data  in  32  result value.
- result_ready  out  1  buffer accepts a result this cycle.
- wb_done  out  1  head entry valid; drives unit_writeback_interface done.
- wb_id  out  id_t  head entry id.
- wb_rd  out  32  head entry data.
- wb_ack  in  1  arbiter selected the head entry this cycle; from unit_writeback_interface ack.
- count  out  $clog2(DEPTH+1)  current occupancy, for unit-side throttling and debug.

## Operation
- Push occurs when result_valid && result_ready. It writes {result_id, result_data} at the write pointer and advances the write pointer.
- Pop occurs when wb_ack && wb_done. It advances the read pointer.
- wb_ack while wb_done=0 is ignored, and the bench flags it as an error.
- result_ready = (count != DEPTH).
  - Readiness is registered state only; there is no combinational path from wb_ack to result_ready.
  - When full, a push is refused even if a pop occurs in the same cycle.
- wb_done = (count != 0).
- wb_id and wb_rd always reflect storage at the read pointer. Their values are don't-care while wb_done=0.
- Occupancy update:
  - push and no pop: count+1.
  - pop and no push: count-1.
  - push and pop together: count unchanged, both pointers advance.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH naturally.
  - For DEPTH=1, pointers are constant 0 and count alone tracks state.
- Ordering is strict FIFO: results retire in acceptance order. The buffer never reorders and never drops a result.
- There is no flush input. Results, once accepted, always reach writeback.

## Timing
- Reset (rst low, asynchronous):
  - count=0, pointers=0, wb_done=0, result_ready=1.
  - Storage entries are cleared to 0, so wb_id=0 and wb_rd=0.
- Latency: a result pushed in cycle N gives wb_done=1 with that entry in cycle N+1 if the buffer was empty. There is no same-cycle bypass.
- Throughput: with DEPTH>=2 and wb_ack held high, the buffer sustains one push and one pop per cycle indefinitely.
- DEPTH=1 limits throughput to one result every 2 cycles under continuous ack.
- When count=1 with simultaneous push and pop, the next cycle's head is the newly pushed entry and wb_done stays 1.
- Reset asserted mid-operation discards all held entries immediately. The first cycle after deassertion behaves as post-reset.
- wb_ack is sampled on the same edge as the push. The arbiter's ack is combinational from wb_done/wb_id, which is legal because wb_done depends only on registered state.

## Structure
- Add a typedef to cva5_types: wb_buffer_entry_t = {id_t id; logic [31:0] data}. Storage is an array of this type.
- DEPTH is a parameter of this block. Per-unit values come from cva5_config alongside the existing unit config.
- No sub-module is needed; this is a single module of pointers, counter and storage array.
- A thin per-unit instantiation connects wb_done/wb_id/wb_rd/wb_ack to the unit's unit_writeback_interface (.unit side).

## Test plan
- Reset, then idle: count=0, wb_done=0, result_ready=1, wb_id=0, wb_rd=0. No change for 10 cycles with no stimulus.
- Single result, DEPTH=2:
  - Push id=3, data=0xDEADBEEF in cycle 5 gives wb_done=1, wb_id=3, wb_rd=0xDEADBEEF in cycle 6.
  - wb_ack in cycle 6 gives wb_done=0 and count=0 in cycle 7.
- Fill and back-pressure, DEPTH=2, wb_ack=0:
  - Push ids 1, 2, 3 on consecutive cycles.
  - Ids 1 and 2 are accepted; result_ready=0 from the third cycle, and id 3 is held by the unit.
  - count=2. Acking then retires 1, then 2, in order.
- Streaming: result_valid and wb_ack held high for 100 cycles with incrementing ids.
  - One retirement per cycle after a 1-cycle fill latency.
  - Retired ids are strictly sequential; no gaps or duplicates; count stays 1.
- Full plus simultaneous ack:
  - count=2, result_valid=1, wb_ack=1: the push is refused that cycle and count becomes 1.
  - The next cycle accepts the push and count returns to 2.
- Async reset mid-stream: drive rst low between clock edges with count=2.
  - Outputs go to reset values immediately, without waiting for clk.
  - After release, the first push appears at wb_done one cycle later with the correct id/data.
